// File: rtl/audio_mixer.sv
// Three-stage audio mixer.
//   Stage 1: per-channel normalisation to signed 16 bits and gain shift.
//   Stage 2: registered sum of all channel words in ACC_W bits.
//   Stage 3: saturation to 16 bits, output register and clip-hold counter.
// A strobe in cycle N produces out_valid in cycle N+3, one sample per cycle.

module audio_mixer #(
    parameter int CHANNELS  = 4,
    parameter int IN_W      = 16,
    parameter int CLIP_HOLD = 1000000
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     in_stb,
    input  logic [CHANNELS*IN_W-1:0] in_data,
    input  logic [CHANNELS-1:0]      in_signed,
    input  logic [CHANNELS*2-1:0]    in_gain,
    output logic [15:0]              out_data,
    output logic                     out_valid,
    output logic                     out_clip
);

    // x4 gain on a full-scale 16-bit value needs 18 bits; the sum of
    // CHANNELS such words needs clog2(CHANNELS) more to never overflow.
    localparam int ACC_W = 18 + $clog2(CHANNELS);
    localparam int CNT_W = $clog2(CLIP_HOLD + 1);
    localparam int SHIFT = 16 - IN_W;

    typedef logic signed [ACC_W-1:0] acc_t;

    localparam acc_t             SAT_MAX   = acc_t'(32767);
    localparam acc_t             SAT_MIN   = acc_t'(-32768);
    localparam logic [CNT_W-1:0] CLIP_LOAD = CNT_W'(CLIP_HOLD);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Normalise one channel and apply its gain. Offset-binary inputs become
    // two's complement by inverting the MSB; narrow samples are left-justified.
    function automatic acc_t scale_sample(
        input logic [IN_W-1:0] raw,
        input logic            is_signed,
        input logic [1:0]      gain
    );
        logic [IN_W-1:0]    adj;
        logic signed [15:0] norm;
        acc_t               ext;
        acc_t               res;
        adj           = raw;
        adj[IN_W-1]   = raw[IN_W-1] ^ ~is_signed;
        norm          = 16'(adj) << SHIFT;
        ext           = acc_t'(norm);
        case (gain)
            2'd0:    res = '0;
            2'd1:    res = ext;
            2'd2:    res = ext <<< 1;
            2'd3:    res = ext <<< 2;
            default: res = '0;
        endcase
        return res;
    endfunction

    acc_t             word_d [CHANNELS];
    acc_t             word_q [CHANNELS];
    logic             valid1_d, valid1_q;
    acc_t             sum_d, sum_q;
    logic             valid2_d, valid2_q;
    logic [15:0]      out_data_d, out_data_q;
    logic             out_valid_d, out_valid_q;
    logic [CNT_W-1:0] clip_cnt_d, clip_cnt_q;
    logic             out_clip_d, out_clip_q;
    logic             clip_event_s;

    // Stage 1: capture data, signedness and gain together on the strobe.
    always_comb begin
        valid1_d = in_stb;
        for (int i = 0; i < CHANNELS; i++) begin
            if (in_stb) begin
                word_d[i] = scale_sample(in_data[i*IN_W +: IN_W],
                                         in_signed[i],
                                         in_gain[i*2 +: 2]);
            end else begin
                word_d[i] = word_q[i];
            end
        end
    end

    // Stage 2: full-width sum of all channel words (a plain register when CHANNELS=1).
    always_comb begin
        valid2_d = valid1_q;
        if (valid1_q) begin
            sum_d = '0;
            for (int i = 0; i < CHANNELS; i++) begin
                sum_d = sum_d + word_q[i];
            end
        end else begin
            sum_d = sum_q;
        end
    end

    // Stage 3: saturate, hold output between updates, run the clip-hold counter.
    always_comb begin
        out_valid_d  = valid2_q;
        out_data_d   = out_data_q;
        clip_event_s = 1'b0;
        if (valid2_q) begin
            if (sum_q > SAT_MAX) begin
                out_data_d   = 16'h7FFF;
                clip_event_s = 1'b1;
            end else if (sum_q < SAT_MIN) begin
                out_data_d   = 16'h8000;
                clip_event_s = 1'b1;
            end else begin
                out_data_d   = sum_q[15:0];
            end
        end else begin
            out_data_d = out_data_q;
        end
        // A new clip reloads the hold time rather than adding to it.
        if (clip_event_s) begin
            clip_cnt_d = CLIP_LOAD;
        end else if (clip_cnt_q != '0) begin
            clip_cnt_d = clip_cnt_q - CNT_ONE;
        end else begin
            clip_cnt_d = clip_cnt_q;
        end
        out_clip_d = (clip_cnt_d != '0);
    end

    // Pipeline and output registers; reset overrides strobe and clip events.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                word_q[i] <= '0;
            end
            valid1_q    <= 1'b0;
            sum_q       <= '0;
            valid2_q    <= 1'b0;
            out_data_q  <= 16'h0000;
            out_valid_q <= 1'b0;
            clip_cnt_q  <= '0;
            out_clip_q  <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                word_q[i] <= word_d[i];
            end
            valid1_q    <= valid1_d;
            sum_q       <= sum_d;
            valid2_q    <= valid2_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            clip_cnt_q  <= clip_cnt_d;
            out_clip_q  <= out_clip_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_clip  = out_clip_q;

endmodule

// File: tb/tb_audio_mixer.sv
// Self-checking bench for audio_mixer: directed scenarios plus randomised
// streams compared against an integer-arithmetic reference model.

module tb_audio_mixer;

    localparam int HOLD = 16;

    typedef struct {
        bit stb;
        int sum;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;

    // Main instance: 4 channels, 16-bit samples.
    logic        a_stb;
    logic [63:0] a_data;
    logic [3:0]  a_sgn;
    logic [7:0]  a_gain;
    logic [15:0] a_out;
    logic        a_valid;
    logic        a_clip;

    // Narrow instance: 3 channels, 10-bit samples.
    logic        n_stb;
    logic [29:0] n_data;
    logic [2:0]  n_sgn;
    logic [5:0]  n_gain;
    logic [15:0] n_out;
    logic        n_valid;
    logic        n_clip;

    int          n_cmp;
    int          n_bad;
    logic [15:0] a_hold;

    audio_mixer #(.CHANNELS(4), .IN_W(16), .CLIP_HOLD(HOLD)) u_dut (
        .clk_sys   (clk),
        .reset     (reset),
        .in_stb    (a_stb),
        .in_data   (a_data),
        .in_signed (a_sgn),
        .in_gain   (a_gain),
        .out_data  (a_out),
        .out_valid (a_valid),
        .out_clip  (a_clip)
    );

    audio_mixer #(.CHANNELS(3), .IN_W(10), .CLIP_HOLD(HOLD)) u_dut_n (
        .clk_sys   (clk),
        .reset     (reset),
        .in_stb    (n_stb),
        .in_data   (n_data),
        .in_signed (n_sgn),
        .in_gain   (n_gain),
        .out_data  (n_out),
        .out_valid (n_valid),
        .out_clip  (n_clip)
    );

    always #5 clk = ~clk;

    // Reference: decode each channel to its integer value, scale, multiply by gain, add.
    function automatic int ref_mix(input int nch, input int inw, input logic [63:0] data,
                                   input logic [7:0] sgn, input logic [15:0] gain);
        int sum;
        int raw;
        int v;
        int g;
        sum = 0;
        for (int i = 0; i < nch; i++) begin
            raw = int'((data >> (i*inw)) & ((64'd1 << inw) - 64'd1));
            if (sgn[i]) v = (raw >= (1 << (inw-1))) ? raw - (1 << inw) : raw;
            else        v = raw - (1 << (inw-1));
            v = v * (1 << (16 - inw));
            g = int'((gain >> (2*i)) & 16'd3);
            sum += (g == 0) ? 0 : v * (1 << (g-1));
        end
        return sum;
    endfunction

    function automatic logic [15:0] sat16(input int s);
        if (s > 32767)       return 16'h7FFF;
        else if (s < -32768) return 16'h8000;
        else                 return 16'(s);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        a_stb = 1'b0;
        n_stb = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        a_stb  = 1'b1;
        n_stb  = 1'b1;
        a_data = {$urandom, $urandom};
        n_data = 30'($urandom);
        for (int i = 0; i < 3; i++) tick();
        n_cmp++; if (a_out !== 16'h0000) begin n_bad++; $display("FAIL reset_out_data: got %h expected %h", a_out, 16'h0000); end
        n_cmp++; if (a_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", a_valid); end
        n_cmp++; if (a_clip !== 1'b0) begin n_bad++; $display("FAIL reset_out_clip: got %b expected 0", a_clip); end
        n_cmp++; if (n_out !== 16'h0000) begin n_bad++; $display("FAIL reset_n_out_data: got %h expected %h", n_out, 16'h0000); end
        n_cmp++; if (n_valid !== 1'b0) begin n_bad++; $display("FAIL reset_n_out_valid: got %b expected 0", n_valid); end
        reset = 1'b0;
        a_stb = 1'b0;
        n_stb = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++; if (a_valid !== 1'b0) begin n_bad++; $display("FAIL reset_no_leak k=%0d: got %b expected 0", k, a_valid); end
        end
        a_hold = 16'h0000;
    endtask

    task automatic test_basic_mix();
        a_sgn  = 4'hF;
        a_gain = 8'h55;
        a_data = {16'd0, 16'd0, 16'hFED4, 16'd1000};
        a_stb  = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            a_stb = 1'b0;
            n_cmp++; if (a_valid !== (k == 3)) begin n_bad++; $display("FAIL basic_valid k=%0d: got %b expected %b", k, a_valid, (k == 3)); end
            if (k == 3) begin
                n_cmp++; if (a_out !== 16'd700) begin n_bad++; $display("FAIL basic_data: got %0d expected 700", $signed(a_out)); end
            end
            n_cmp++; if (a_clip !== 1'b0) begin n_bad++; $display("FAIL basic_clip k=%0d: got %b expected 0", k, a_clip); end
        end
        a_hold = 16'd700;
    endtask

    task automatic test_unsigned_narrow();
        logic [9:0]  codes [3] = '{10'h3FF, 10'h200, 10'h000};
        logic [15:0] exps  [3] = '{16'h7FC0, 16'h0000, 16'h8000};
        n_sgn  = 3'b000;
        n_gain = 6'b000001;
        for (int r = 0; r < 3; r++) begin
            n_data = {20'($urandom), codes[r]};
            n_stb  = 1'b1;
            for (int k = 1; k <= 4; k++) begin
                tick();
                n_stb = 1'b0;
                n_cmp++; if (n_valid !== (k == 3)) begin n_bad++; $display("FAIL narrow_valid r=%0d k=%0d: got %b expected %b", r, k, n_valid, (k == 3)); end
                if (k >= 3) begin
                    n_cmp++; if (n_out !== exps[r]) begin n_bad++; $display("FAIL narrow_data r=%0d: got %h expected %h", r, n_out, exps[r]); end
                    n_cmp++; if (n_clip !== 1'b0) begin n_bad++; $display("FAIL narrow_clip r=%0d: got %b expected 0", r, n_clip); end
                end
            end
        end
    endtask

    task automatic test_pos_sat();
        bit exp_clip;
        bit exp_valid;
        a_sgn  = 4'hF;
        a_gain = 8'h55;
        a_data = {32'd0, 16'd20000, 16'd20000};
        a_stb  = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            a_stb     = (k == 10);
            exp_valid = (k == 3) || (k == 13);
            exp_clip  = (k >= 3 && k < 3 + HOLD) || (k >= 13 && k < 13 + HOLD);
            n_cmp++; if (a_valid !== exp_valid) begin n_bad++; $display("FAIL possat_valid k=%0d: got %b expected %b", k, a_valid, exp_valid); end
            n_cmp++; if (a_clip !== exp_clip) begin n_bad++; $display("FAIL possat_clip k=%0d: got %b expected %b", k, a_clip, exp_clip); end
            if (exp_valid) begin
                n_cmp++; if (a_out !== 16'h7FFF) begin n_bad++; $display("FAIL possat_data k=%0d: got %h expected 7fff", k, a_out); end
            end
        end
        a_hold = 16'h7FFF;
    endtask

    task automatic test_neg_edge();
        logic [15:0] ch0 [2] = '{16'hC000, 16'hBFFF};
        bit          clp [2] = '{1'b0, 1'b1};
        bit          exp_clip;
        a_sgn  = 4'hF;
        a_gain = 8'h56;
        for (int r = 0; r < 2; r++) begin
            a_data = {48'd0, ch0[r]};
            a_stb  = 1'b1;
            for (int k = 1; k <= 5; k++) begin
                tick();
                a_stb    = 1'b0;
                exp_clip = clp[r] && (k >= 3);
                n_cmp++; if (a_valid !== (k == 3)) begin n_bad++; $display("FAIL neg_valid r=%0d k=%0d: got %b expected %b", r, k, a_valid, (k == 3)); end
                n_cmp++; if (a_clip !== exp_clip) begin n_bad++; $display("FAIL neg_clip r=%0d k=%0d: got %b expected %b", r, k, a_clip, exp_clip); end
                if (k >= 3) begin
                    n_cmp++; if (a_out !== 16'h8000) begin n_bad++; $display("FAIL neg_data r=%0d: got %h expected 8000", r, a_out); end
                end
            end
        end
        a_hold = 16'h8000;
    endtask

    task automatic test_throughput();
        ent_t q[$];
        ent_t e;
        int   last_clip;
        bit   exp_clip;
        idle(HOLD + 4);
        last_clip = -1000;
        for (int t = 0; t < 68; t++) begin
            if (q.size() >= 3) begin
                e = q.pop_front();
                n_cmp++; if (a_valid !== e.stb) begin n_bad++; $display("FAIL tput_valid t=%0d: got %b expected %b", t, a_valid, e.stb); end
                if (e.stb) begin
                    a_hold = sat16(e.sum);
                    if (e.sum > 32767 || e.sum < -32768) last_clip = t;
                end
                exp_clip = (t - last_clip) < HOLD;
                n_cmp++; if (a_out !== a_hold) begin n_bad++; $display("FAIL tput_data t=%0d: got %h expected %h", t, a_out, a_hold); end
                n_cmp++; if (a_clip !== exp_clip) begin n_bad++; $display("FAIL tput_clip t=%0d: got %b expected %b", t, a_clip, exp_clip); end
            end
            if (t < 64) begin
                a_data = {16'($urandom), 16'($urandom), 16'($urandom), 16'(t*1000 - 32000)};
                a_sgn  = 4'($urandom);
                a_gain = 8'($urandom);
                a_stb  = 1'b1;
                e.stb  = 1'b1;
                e.sum  = ref_mix(4, 16, a_data, {4'd0, a_sgn}, {8'd0, a_gain});
            end else begin
                a_stb = 1'b0;
                e.stb = 1'b0;
                e.sum = 0;
            end
            q.push_back(e);
            tick();
        end
    endtask

    task automatic test_random();
        ent_t q[$];
        ent_t e;
        int   last_clip;
        bit   exp_clip;
        idle(HOLD + 4);
        last_clip = -1000;
        for (int t = 0; t < 240; t++) begin
            if (q.size() >= 3) begin
                e = q.pop_front();
                n_cmp++; if (a_valid !== e.stb) begin n_bad++; $display("FAIL rand_valid t=%0d: got %b expected %b", t, a_valid, e.stb); end
                if (e.stb) begin
                    a_hold = sat16(e.sum);
                    if (e.sum > 32767 || e.sum < -32768) last_clip = t;
                end
                exp_clip = (t - last_clip) < HOLD;
                n_cmp++; if (a_out !== a_hold) begin n_bad++; $display("FAIL rand_data t=%0d: got %h expected %h", t, a_out, a_hold); end
                n_cmp++; if (a_clip !== exp_clip) begin n_bad++; $display("FAIL rand_clip t=%0d: got %b expected %b", t, a_clip, exp_clip); end
            end
            // Inputs change every cycle, strobed or not, so in-flight samples must be unaffected.
            a_data = {$urandom, $urandom};
            a_sgn  = 4'($urandom);
            a_gain = 8'($urandom);
            a_stb  = (t < 236) ? 1'($urandom_range(0, 1)) : 1'b0;
            e.stb  = a_stb;
            e.sum  = ref_mix(4, 16, a_data, {4'd0, a_sgn}, {8'd0, a_gain});
            q.push_back(e);
            tick();
        end
    endtask

    task automatic test_reset_midflight();
        int s;
        idle(HOLD + 4);
        a_sgn  = 4'hF;
        a_gain = 8'h55;
        a_data = {32'd0, 16'd20000, 16'd20000};
        a_stb  = 1'b1;
        tick();
        tick();
        a_data = {$urandom, $urandom};
        tick();
        a_stb = 1'b0;
        reset = 1'b1;
        n_cmp++; if (a_valid !== 1'b1) begin n_bad++; $display("FAIL rmid_pre_valid: got %b expected 1", a_valid); end
        n_cmp++; if (a_clip !== 1'b1) begin n_bad++; $display("FAIL rmid_pre_clip: got %b expected 1", a_clip); end
        n_cmp++; if (a_out !== 16'h7FFF) begin n_bad++; $display("FAIL rmid_pre_data: got %h expected 7fff", a_out); end
        tick();
        reset = 1'b0;
        n_cmp++; if (a_out !== 16'h0000) begin n_bad++; $display("FAIL rmid_rst_data: got %h expected 0000", a_out); end
        n_cmp++; if (a_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_rst_valid: got %b expected 0", a_valid); end
        n_cmp++; if (a_clip !== 1'b0) begin n_bad++; $display("FAIL rmid_rst_clip: got %b expected 0", a_clip); end
        a_data = {$urandom, $urandom};
        a_sgn  = 4'($urandom);
        a_gain = 8'($urandom);
        a_stb  = 1'b1;
        s      = ref_mix(4, 16, a_data, {4'd0, a_sgn}, {8'd0, a_gain});
        for (int k = 1; k <= 4; k++) begin
            tick();
            a_stb = 1'b0;
            n_cmp++; if (a_valid !== (k == 3)) begin n_bad++; $display("FAIL rmid_valid k=%0d: got %b expected %b", k, a_valid, (k == 3)); end
            if (k < 3) begin
                n_cmp++; if (a_out !== 16'h0000) begin n_bad++; $display("FAIL rmid_hold k=%0d: got %h expected 0000", k, a_out); end
                n_cmp++; if (a_clip !== 1'b0) begin n_bad++; $display("FAIL rmid_clip k=%0d: got %b expected 0", k, a_clip); end
            end else begin
                n_cmp++; if (a_out !== sat16(s)) begin n_bad++; $display("FAIL rmid_data k=%0d: got %h expected %h", k, a_out, sat16(s)); end
                n_cmp++; if (a_clip !== (s > 32767 || s < -32768)) begin n_bad++; $display("FAIL rmid_post_clip k=%0d: got %b expected %b", k, a_clip, (s > 32767 || s < -32768)); end
            end
        end
        a_hold = sat16(s);
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        a_hold = 16'h0000;
        reset  = 1'b1;
        a_stb  = 1'b0;
        a_data = 64'd0;
        a_sgn  = 4'd0;
        a_gain = 8'd0;
        n_stb  = 1'b0;
        n_data = 30'd0;
        n_sgn  = 3'd0;
        n_gain = 6'd0;
        test_reset();
        test_basic_mix();
        test_unsigned_narrow();
        test_pos_sat();
        test_neg_edge();
        test_throughput();
        test_random();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
